// File: rtl/hid_frame_tx.sv
// hid_frame_tx: queues key/mouse/joystick events and serialises them as framed
// command byte streams toward the core HID receiver; services DB9 change polls.
module hid_frame_tx #(
  parameter int GAP      = 4,
  parameter int KFIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [6:0] key_event,
  output logic       key_ready,
  output logic       key_overflow,
  input  logic       mouse_valid,
  input  logic [1:0] mouse_btns,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  input  logic       joy_valid,
  input  logic [7:0] joy_device,
  input  logic [7:0] joy_digital,
  input  logic [7:0] joy_a0,
  input  logic [7:0] joy_a1,
  input  logic       irq,
  output logic       iack,
  input  logic [7:0] data_resp,
  output logic       data_strobe,
  output logic       data_start,
  output logic [7:0] data_byte,
  output logic [5:0] db9_state,
  output logic       db9_valid,
  output logic       busy
);

  // state     | meaning
  // S_IDLE    | arbitrate pending sources, latch frame, register byte-0 strobe
  // S_SEND    | strobe for byte idx is on the outputs
  // S_GAP     | spacing before next byte (or frame end)
  // S_CAPTURE | sample the DB9 reply of a poll frame
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_CAPTURE} state_t;

  localparam int                CW       = $clog2(GAP + 1);
  localparam int                KDEPTH   = 1 << KFIFO_AW;
  localparam logic [CW-1:0]     GAP_LOAD = CW'(GAP - 2);
  localparam logic [KFIFO_AW:0] KFULL    = (KFIFO_AW + 1)'(KDEPTH);

  state_t state, state_next;
  logic [2:0] idx, idx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0] last_q;
  logic poll_q;
  logic [7:0] frame_q [5];

  logic strobe_n, start_n, iack_n, busy_n;
  logic [7:0] byte_n;

  logic [6:0] kmem [KDEPTH];
  logic [KFIFO_AW-1:0] wptr, rptr;
  logic [KFIFO_AW:0] kcount;
  logic kfull, kempty, push, pop;
  logic [6:0] key_head;

  logic mouse_pend, joy_pend;
  logic [1:0] mouse_btns_q;
  logic [7:0] mouse_dx_q, mouse_dy_q;
  logic [7:0] joy_device_q, joy_digital_q, joy_a0_q, joy_a1_q;

  logic sel_poll, sel_joy, sel_mouse, sel_key, start_frame;
  logic [7:0] sel_bytes [5];
  logic [2:0] sel_last;

  logic resp_unused;
  assign resp_unused = ^data_resp[7:6];

  assign kfull     = (kcount == KFULL);
  assign kempty    = (kcount == '0);
  assign key_ready = !kfull;
  assign key_head  = kmem[rptr];
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign pop       = start_frame && sel_key;
  assign push      = key_valid && (!kfull || pop);

  always_comb begin
    sel_poll    = irq;
    sel_joy     = !irq && joy_pend;
    sel_mouse   = !irq && !joy_pend && mouse_pend;
    sel_key     = !irq && !joy_pend && !mouse_pend && !kempty;
    start_frame = (state == S_IDLE) && (sel_poll || sel_joy || sel_mouse || sel_key);
    for (int i = 0; i < 5; i++) sel_bytes[i] = 8'h00;
    sel_last = 3'd1;
    if (sel_poll) begin
      sel_bytes[0] = 8'h04;
    end else if (sel_joy) begin
      sel_bytes[0] = 8'h03;
      sel_bytes[1] = joy_device_q;
      sel_bytes[2] = joy_digital_q;
      sel_bytes[3] = joy_a0_q;
      sel_bytes[4] = joy_a1_q;
      sel_last     = 3'd4;
    end else if (sel_mouse) begin
      sel_bytes[0] = 8'h02;
      sel_bytes[1] = {6'b0, mouse_btns_q};
      sel_bytes[2] = mouse_dx_q;
      sel_bytes[3] = mouse_dy_q;
      sel_last     = 3'd3;
    end else begin
      sel_bytes[0] = 8'h01;
      sel_bytes[1] = {~key_head[6], 1'b0, key_head[5:0]};
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    strobe_n   = 1'b0;
    start_n    = 1'b0;
    iack_n     = 1'b0;
    byte_n     = data_byte;
    case (state)
      S_IDLE: begin
        if (start_frame) begin
          state_next = S_SEND;
          idx_next   = 3'd0;
          strobe_n   = 1'b1;
          start_n    = 1'b1;
          iack_n     = sel_poll;
          byte_n     = sel_bytes[0];
        end
      end
      S_SEND: begin
        state_next = S_GAP;
        cnt_next   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (idx != last_q) begin
          idx_next   = idx + 3'd1;
          state_next = S_SEND;
          strobe_n   = 1'b1;
          byte_n     = frame_q[idx + 3'd1];
        end else if (poll_q) begin
          state_next = S_CAPTURE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    busy_n = (state_next == S_SEND) || (state_next == S_GAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      last_q      <= '0;
      poll_q      <= 1'b0;
      data_strobe <= 1'b0;
      data_start  <= 1'b0;
      data_byte   <= 8'h00;
      iack        <= 1'b0;
      busy        <= 1'b0;
      db9_valid   <= 1'b0;
      db9_state   <= 6'h00;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      cnt         <= cnt_next;
      data_strobe <= strobe_n;
      data_start  <= start_n;
      data_byte   <= byte_n;
      iack        <= iack_n;
      busy        <= busy_n;
      db9_valid   <= (state == S_CAPTURE);
      if (state == S_CAPTURE) db9_state <= data_resp[5:0];
      if (start_frame) begin
        last_q <= sel_last;
        poll_q <= sel_poll;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_frame) frame_q <= sel_bytes;
    if (push) kmem[wptr] <= key_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr          <= '0;
      rptr          <= '0;
      kcount        <= '0;
      key_overflow  <= 1'b0;
      mouse_pend    <= 1'b0;
      joy_pend      <= 1'b0;
      mouse_btns_q  <= '0;
      mouse_dx_q    <= '0;
      mouse_dy_q    <= '0;
      joy_device_q  <= '0;
      joy_digital_q <= '0;
      joy_a0_q      <= '0;
      joy_a1_q      <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   kcount <= kcount + 1'b1;
        2'b01:   kcount <= kcount - 1'b1;
        default: kcount <= kcount;
      endcase
      if (key_valid && kfull && !pop) key_overflow <= 1'b1;
      // a valid in the frame-start cycle wins: the frame takes the old snapshot
      if (mouse_valid) begin
        mouse_pend   <= 1'b1;
        mouse_btns_q <= mouse_btns;
        mouse_dx_q   <= mouse_dx;
        mouse_dy_q   <= mouse_dy;
      end else if (start_frame && sel_mouse) begin
        mouse_pend <= 1'b0;
      end
      if (joy_valid) begin
        joy_pend      <= 1'b1;
        joy_device_q  <= joy_device;
        joy_digital_q <= joy_digital;
        joy_a0_q      <= joy_a0;
        joy_a1_q      <= joy_a1;
      end else if (start_frame && sel_joy) begin
        joy_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hid_frame_tx.sv
// Directed bench for hid_frame_tx: frames, FIFO overflow, latest-wins holding,
// priority with DB9 poll capture, and reset in the middle of a frame.
module tb_hid_frame_tx;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [6:0] key_event = '0;
  logic       key_ready, key_overflow;
  logic       mouse_valid = 1'b0;
  logic [1:0] mouse_btns = '0;
  logic [7:0] mouse_dx = '0, mouse_dy = '0;
  logic       joy_valid = 1'b0;
  logic [7:0] joy_device = '0, joy_digital = '0, joy_a0 = '0, joy_a1 = '0;
  logic       irq = 1'b0;
  logic       iack;
  logic [7:0] data_resp = '0;
  logic       data_strobe, data_start;
  logic [7:0] data_byte;
  logic [5:0] db9_state;
  logic       db9_valid, busy;

  hid_frame_tx #(.GAP(GAP), .KFIFO_AW(3)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_event(key_event), .key_ready(key_ready), .key_overflow(key_overflow),
    .mouse_valid(mouse_valid), .mouse_btns(mouse_btns), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .joy_valid(joy_valid), .joy_device(joy_device), .joy_digital(joy_digital), .joy_a0(joy_a0), .joy_a1(joy_a1),
    .irq(irq), .iack(iack), .data_resp(data_resp),
    .data_strobe(data_strobe), .data_start(data_start), .data_byte(data_byte),
    .db9_state(db9_state), .db9_valid(db9_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mon_byte [$];
  bit         mon_start [$];
  bit         mon_iack [$];
  int         mon_cyc [$];
  int iack_cnt = 0, dbv_cnt = 0, dbv_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (data_strobe) begin
      mon_byte.push_back(data_byte);
      mon_start.push_back(data_start);
      mon_iack.push_back(iack);
      mon_cyc.push_back(cyc);
    end
    if (iack) iack_cnt++;
    if (db9_valid) begin
      dbv_cnt++;
      dbv_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_size(input int n, input int budget, output bit ok);
    while (mon_byte.size() < n && budget > 0) begin
      step();
      budget--;
    end
    ok = (mon_byte.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet = 0;
    while (quiet < 6 && budget > 0) begin
      step();
      budget--;
      if (!busy && !data_strobe) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 6);
  endtask

  task automatic test_reset();
    logic [26:0] got;
    reset = 1'b1;
    repeat (3) step();
    got = {data_strobe, data_start, data_byte, iack, db9_valid, busy, key_overflow, db9_state, key_ready};
    checks++;
    if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got %h want %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_key_frame();
    int base, push_c, busy_base;
    bit ok;
    base = mon_byte.size();
    busy_base = busy_cnt;
    key_event = 7'h5D;
    key_valid = 1'b1;
    step();
    push_c = cyc;
    key_valid = 1'b0;
    wait_size(base + 2, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL key_frame_timeout got %0d strobes want 2", mon_byte.size() - base); end
    wait_idle(60, ok);
    if (mon_byte.size() >= base + 2) begin
      checks++;
      if (mon_byte[base] !== 8'h01 || mon_start[base] !== 1'b1) begin
        errors++; $display("FAIL key_byte0 got %h/%b want 01/1", mon_byte[base], mon_start[base]);
      end
      checks++;
      if (mon_byte[base+1] !== 8'h1D || mon_start[base+1] !== 1'b0) begin
        errors++; $display("FAIL key_byte1 got %h/%b want 1d/0", mon_byte[base+1], mon_start[base+1]);
      end
      checks++;
      if (mon_cyc[base] !== push_c + 1) begin
        errors++; $display("FAIL key_latency got %0d want %0d", mon_cyc[base] - push_c, 1);
      end
      checks++;
      if (mon_cyc[base+1] - mon_cyc[base] !== GAP) begin
        errors++; $display("FAIL key_spacing got %0d want %0d", mon_cyc[base+1] - mon_cyc[base], GAP);
      end
    end
    checks++;
    if (busy_cnt - busy_base !== 2 * GAP) begin
      errors++; $display("FAIL key_busy_len got %0d want %0d", busy_cnt - busy_base, 2 * GAP);
    end
    checks++;
    if (data_byte !== 8'h1D) begin
      errors++; $display("FAIL key_byte_hold got %h want 1d", data_byte);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] ev [9];
    logic [7:0] exp_b [26];
    int base;
    bit ok, exp_s;
    ev = '{7'h40, 7'h0A, 7'h7F, 7'h21, 7'h56, 7'h2B, 7'h74, 7'h18, 7'h49};
    exp_b = '{8'h03, 8'h11, 8'h22, 8'h80, 8'h7F, 8'h03, 8'h11, 8'h22, 8'h80, 8'h7F,
              8'h01, 8'h00, 8'h01, 8'h8A, 8'h01, 8'h3F, 8'h01, 8'hA1,
              8'h01, 8'h16, 8'h01, 8'hAB, 8'h01, 8'h34, 8'h01, 8'h98};
    base = mon_byte.size();
    joy_device = 8'h11; joy_digital = 8'h22; joy_a0 = 8'h80; joy_a1 = 8'h7F;
    for (int i = 0; i < 9; i++) begin
      key_event = ev[i];
      key_valid = 1'b1;
      joy_valid = 1'b1;
      step();
      if (i == 6) begin
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_7 got %b want 1", key_ready); end
      end
      if (i == 7) begin
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_full got %b want 0", key_ready); end
        checks++;
        if (key_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", key_overflow); end
      end
    end
    key_valid = 1'b0;
    joy_valid = 1'b0;
    checks++;
    if (key_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", key_overflow); end
    wait_size(base + 26, 500, ok);
    wait_idle(100, ok);
    checks++;
    if (mon_byte.size() !== base + 26) begin
      errors++; $display("FAIL ovf_count got %0d want 26", mon_byte.size() - base);
    end
    if (mon_byte.size() >= base + 26) begin
      for (int i = 0; i < 26; i++) begin
        exp_s = (i == 0 || i == 5 || (i >= 10 && ((i - 10) % 2) == 0));
        checks++;
        if (mon_byte[base+i] !== exp_b[i] || mon_start[base+i] !== exp_s) begin
          errors++;
          $display("FAIL ovf_byte%0d got %h/%b want %h/%b", i, mon_byte[base+i], mon_start[base+i], exp_b[i], exp_s);
        end
      end
    end
    checks++;
    if (key_ready !== 1'b1 || key_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after got ready=%b ovf=%b want 1 1", key_ready, key_overflow);
    end
  endtask

  task automatic test_mouse_latest();
    logic [7:0] exp_b [8];
    int base;
    bit ok;
    exp_b = '{8'h02, 8'h01, 8'h05, 8'hFB, 8'h02, 8'h01, 8'h07, 8'hFB};
    base = mon_byte.size();
    mouse_btns = 2'b01; mouse_dx = 8'h05; mouse_dy = 8'hFB;
    mouse_valid = 1'b1;
    step();
    mouse_valid = 1'b0;
    repeat (5) step();
    mouse_dx = 8'h07;
    mouse_valid = 1'b1;
    step();
    mouse_valid = 1'b0;
    wait_size(base + 8, 120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mouse_timeout got %0d strobes want 8", mon_byte.size() - base); end
    wait_idle(60, ok);
    if (mon_byte.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_byte[base+i] !== exp_b[i] || mon_start[base+i] !== (i % 4 == 0)) begin
          errors++;
          $display("FAIL mouse_byte%0d got %h/%b want %h/%b", i, mon_byte[base+i], mon_start[base+i], exp_b[i], (i % 4 == 0));
        end
      end
    end
  endtask

  task automatic test_priority_poll();
    logic [7:0] exp_b [13];
    int base, iack_base, dbv_base;
    bit ok, exp_s;
    exp_b = '{8'h04, 8'h00, 8'h03, 8'h05, 8'hA5, 8'h10, 8'hF0,
              8'h02, 8'h02, 8'h33, 8'hCC, 8'h01, 8'h1D};
    base = mon_byte.size();
    iack_base = iack_cnt;
    dbv_base = dbv_cnt;
    data_resp = 8'h2A;
    key_event = 7'h5D; key_valid = 1'b1;
    mouse_btns = 2'b10; mouse_dx = 8'h33; mouse_dy = 8'hCC; mouse_valid = 1'b1;
    joy_device = 8'h05; joy_digital = 8'hA5; joy_a0 = 8'h10; joy_a1 = 8'hF0; joy_valid = 1'b1;
    irq = 1'b1;
    step();
    key_valid = 1'b0; mouse_valid = 1'b0; joy_valid = 1'b0; irq = 1'b0;
    wait_size(base + 13, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prio_timeout got %0d strobes want 13", mon_byte.size() - base); end
    wait_idle(60, ok);
    if (mon_byte.size() >= base + 13) begin
      for (int i = 0; i < 13; i++) begin
        exp_s = (i == 0 || i == 2 || i == 7 || i == 11);
        checks++;
        if (mon_byte[base+i] !== exp_b[i] || mon_start[base+i] !== exp_s) begin
          errors++;
          $display("FAIL prio_byte%0d got %h/%b want %h/%b", i, mon_byte[base+i], mon_start[base+i], exp_b[i], exp_s);
        end
      end
      checks++;
      if (mon_iack[base] !== 1'b1) begin errors++; $display("FAIL poll_iack_align got %b want 1", mon_iack[base]); end
      checks++;
      if (dbv_cyc !== mon_cyc[base+1] + GAP + 1) begin
        errors++; $display("FAIL poll_capture_time got %0d want %0d", dbv_cyc - mon_cyc[base+1], GAP + 1);
      end
      checks++;
      if (mon_cyc[base+2] - mon_cyc[base+1] !== GAP + 2) begin
        errors++; $display("FAIL b2b_poll_joy got %0d want %0d", mon_cyc[base+2] - mon_cyc[base+1], GAP + 2);
      end
      checks++;
      if (mon_cyc[base+3] - mon_cyc[base+2] !== GAP) begin
        errors++; $display("FAIL joy_spacing got %0d want %0d", mon_cyc[base+3] - mon_cyc[base+2], GAP);
      end
      checks++;
      if (mon_cyc[base+7] - mon_cyc[base+6] !== GAP + 1) begin
        errors++; $display("FAIL b2b_joy_mouse got %0d want %0d", mon_cyc[base+7] - mon_cyc[base+6], GAP + 1);
      end
      checks++;
      if (mon_cyc[base+11] - mon_cyc[base+10] !== GAP + 1) begin
        errors++; $display("FAIL b2b_mouse_key got %0d want %0d", mon_cyc[base+11] - mon_cyc[base+10], GAP + 1);
      end
    end
    checks++;
    if (iack_cnt - iack_base !== 1) begin errors++; $display("FAIL poll_iack_count got %0d want 1", iack_cnt - iack_base); end
    checks++;
    if (dbv_cnt - dbv_base !== 1) begin errors++; $display("FAIL poll_db9_valid_count got %0d want 1", dbv_cnt - dbv_base); end
    checks++;
    if (db9_state !== 6'h2A) begin errors++; $display("FAIL poll_db9_state got %h want 2a", db9_state); end
  endtask

  task automatic test_reset_mid_frame();
    logic [26:0] got;
    logic [7:0] exp_b [4];
    int base, b;
    bit ok;
    exp_b = '{8'h02, 8'h03, 8'h01, 8'h02};
    checks++;
    if (key_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", key_overflow); end
    base = mon_byte.size();
    key_event = 7'h5D; key_valid = 1'b1;
    joy_device = 8'h44; joy_digital = 8'h55; joy_a0 = 8'h66; joy_a1 = 8'h77; joy_valid = 1'b1;
    step();
    key_valid = 1'b0; joy_valid = 1'b0;
    wait_size(base + 2, 60, ok);
    mouse_btns = 2'b10; mouse_dx = 8'hAA; mouse_dy = 8'hBB; mouse_valid = 1'b1;
    step();
    mouse_valid = 1'b0;
    b = 60;
    while (mon_byte.size() < base + 3 && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    checks++;
    if (mon_byte.size() !== base + 3) begin
      errors++; $display("FAIL rst_reach_byte2 got %0d strobes want 3", mon_byte.size() - base);
    end
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    got = {data_strobe, data_start, data_byte, iack, db9_valid, busy, key_overflow, db9_state, key_ready};
    checks++;
    if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_values got %h want %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1});
    end
    repeat (40) step();
    checks++;
    if (mon_byte.size() !== base + 3) begin
      errors++; $display("FAIL rst_no_strobes got %0d strobes want 3", mon_byte.size() - base);
    end
    mouse_btns = 2'b11; mouse_dx = 8'h01; mouse_dy = 8'h02; mouse_valid = 1'b1;
    step();
    mouse_valid = 1'b0;
    wait_size(base + 7, 120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_fresh_timeout got %0d strobes want 7", mon_byte.size() - base); end
    if (mon_byte.size() >= base + 7) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_byte[base+3+i] !== exp_b[i] || mon_start[base+3+i] !== (i == 0)) begin
          errors++;
          $display("FAIL rst_fresh_byte%0d got %h/%b want %h/%b", i, mon_byte[base+3+i], mon_start[base+3+i], exp_b[i], (i == 0));
        end
      end
    end
    wait_idle(60, ok);
    repeat (30) step();
    checks++;
    if (mon_byte.size() !== base + 7) begin
      errors++; $display("FAIL rst_fifo_empty got %0d strobes want 7", mon_byte.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_key_frame();
    test_overflow();
    test_mouse_latest();
    test_priority_poll();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
